// File: rtl/glip_deframer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : glip_deframer_pkg
// Purpose  : Shared types and header-field constants for the GLIP stream
//            deframer (state encoding, header bit positions, checksum width).
// Ports    : n/a (package)
// Options  : none
// Revision : 1.0 - initial release
// ============================================================================
package glip_deframer_pkg;

    // Deframer FSM states
    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        PAYLOAD = 2'd1,
        CHECK   = 2'd2
    } state_t;

    // Header word layout: [15:12] sync nibble, [11:0] payload length
    localparam int SYNC_MSB = 15;
    localparam int SYNC_LSB = 12;
    localparam int LEN_MSB  = 11;
    localparam int LEN_LSB  = 0;
    localparam int LEN_W    = LEN_MSB - LEN_LSB + 1;

    // Checksum is a plain 16-bit wrapping sum of the payload words
    localparam int CSUM_W   = 16;

endpackage : glip_deframer_pkg
`default_nettype wire

// File: rtl/glip_out_stage.sv
`default_nettype none
// ============================================================================
// Module   : glip_out_stage
// Purpose  : Single-entry valid/ready output register carrying data + last.
//            Gives one cycle of latency while sustaining full throughput.
// Ports    : clk, rst_n          - clock, async active-low reset
//            load, load_data,
//            load_last           - write a new entry (only when can_load)
//            can_load            - register is empty or being drained now
//            out_valid/out_ready - downstream handshake
//            out_data, out_last  - registered entry
// Options  : none
// Revision : 1.0 - initial release
// ============================================================================
module glip_out_stage #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    output logic              can_load,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last
);

    assign can_load = !out_valid || out_ready;

    // Data and last only change on a load, so they stay stable during a stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= load_data;
            out_last  <= load_last;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule : glip_out_stage
`default_nettype wire

// File: rtl/glip_stream_deframer.sv
`default_nettype none
// ============================================================================
// Module   : glip_stream_deframer
// Purpose  : Recovers frames (header, N payload words, checksum) from the
//            16-bit GLIP FIFO-in stream of the FX3 toplevel. Payload words are
//            delivered with a last marker; each frame end yields a one-cycle
//            status pulse with a checksum pass/fail flag.
// Ports    : clk, rst_n                   - clock, async active-low reset
//            in_valid/in_ready/in_data    - input stream (from fifo_in)
//            out_valid/out_ready/out_data,
//            out_last                     - payload stream
//            status_valid, status_ok      - per-frame checksum result
//            busy                         - frame in progress (state != HUNT)
//            frames_ok, frames_err,
//            resync_drops                 - saturating statistics counters,
//                                           only with GLIP_DEFRAMER_STATS_EN
// Options  : GLIP_DEFRAMER_STATS_EN - adds the statistics counters/ports
// Revision : 1.0 - initial release
// ============================================================================
module glip_stream_deframer
    import glip_deframer_pkg::*;
#(
    parameter logic [3:0] SYNC   = 4'hA,
    parameter int         MAXLEN = 4095
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic        out_last,
    output logic        status_valid,
    output logic        status_ok,
`ifdef GLIP_DEFRAMER_STATS_EN
    output logic [15:0] frames_ok,
    output logic [15:0] frames_err,
    output logic [15:0] resync_drops,
`endif
    output logic        busy
);

    localparam logic [LEN_W-1:0] MAXLEN_L = LEN_W'(MAXLEN);
    localparam logic [LEN_W-1:0] ONE_L    = LEN_W'(1);

    state_t              r_state;
    logic [LEN_W-1:0]    r_len;
    logic [LEN_W-1:0]    r_cnt;
    logic [CSUM_W-1:0]   r_sum;

    logic                w_can_load;
    logic                w_accept;
    logic                w_hdr_sync;
    logic [LEN_W-1:0]    w_hdr_len;
    logic                w_hdr_len_ok;
    logic                w_load;
    logic                w_last;
    logic                w_chk_done;
    logic                w_sum_match;
    logic                w_drop;

    assign w_hdr_sync   = (in_data[SYNC_MSB:SYNC_LSB] == SYNC);
    assign w_hdr_len    = in_data[LEN_MSB:LEN_LSB];
    assign w_hdr_len_ok = (w_hdr_len <= MAXLEN_L);

    // Only PAYLOAD is throttled by the output register; the checksum word is
    // consumed internally, so CHECK accepts regardless of out_ready.
    always_comb begin
        in_ready = 1'b1;
        case (r_state)
            HUNT:    in_ready = 1'b1;
            PAYLOAD: in_ready = w_can_load;
            CHECK:   in_ready = 1'b1;
            default: in_ready = 1'b1;
        endcase
    end

    assign w_accept    = in_valid && in_ready;
    assign w_load      = (r_state == PAYLOAD) && w_accept;
    assign w_last      = (r_cnt == (r_len - ONE_L));
    assign w_chk_done  = (r_state == CHECK) && w_accept;
    assign w_sum_match = (in_data == r_sum);
    assign w_drop      = (r_state == HUNT) && w_accept && !(w_hdr_sync && w_hdr_len_ok);
    assign busy        = (r_state != HUNT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= HUNT;
            r_len        <= '0;
            r_cnt        <= '0;
            r_sum        <= '0;
            status_valid <= 1'b0;
            status_ok    <= 1'b0;
        end else begin
            status_valid <= 1'b0;
            case (r_state)
                HUNT: begin
                    if (w_accept && w_hdr_sync && w_hdr_len_ok) begin
                        // A zero-length header goes straight to CHECK with
                        // an expected checksum of zero.
                        r_len   <= w_hdr_len;
                        r_cnt   <= '0;
                        r_sum   <= '0;
                        r_state <= (w_hdr_len == '0) ? CHECK : PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    if (w_accept) begin
                        r_sum <= r_sum + in_data;
                        r_cnt <= r_cnt + ONE_L;
                        if (w_last) begin
                            r_state <= CHECK;
                        end
                    end
                end
                CHECK: begin
                    if (w_accept) begin
                        status_valid <= 1'b1;
                        status_ok    <= w_sum_match;
                        r_state      <= HUNT;
                    end
                end
                default: r_state <= HUNT;
            endcase
        end
    end

    glip_out_stage #(
        .DATA_W (16)
    ) u_out_stage (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (w_load),
        .load_data (in_data),
        .load_last (w_last),
        .can_load  (w_can_load),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last)
    );

`ifdef GLIP_DEFRAMER_STATS_EN
    // Saturating counters: hold at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frames_ok    <= '0;
            frames_err   <= '0;
            resync_drops <= '0;
        end else begin
            if (w_chk_done && w_sum_match && (frames_ok != '1)) begin
                frames_ok <= frames_ok + 16'd1;
            end
            if (w_chk_done && !w_sum_match && (frames_err != '1)) begin
                frames_err <= frames_err + 16'd1;
            end
            if (w_drop && (resync_drops != '1)) begin
                resync_drops <= resync_drops + 16'd1;
            end
        end
    end
`else
    // Drop detection only feeds the statistics counters.
    logic w_unused_drop;
    assign w_unused_drop = w_drop;
`endif

endmodule : glip_stream_deframer
`default_nettype wire

// File: tb/tb_glip_stream_deframer.sv
`default_nettype none
// ============================================================================
// Module   : tb_glip_stream_deframer
// Purpose  : Directed self-checking bench for glip_stream_deframer
//            (MAXLEN overridden to 16 so the length boundary is reachable).
// Options  : GLIP_DEFRAMER_STATS_EN - also checks the statistics counters
// Revision : 1.0 - initial release
// ============================================================================
module tb_glip_stream_deframer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = 16'h0000;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_data;
    logic        out_last;
    logic        status_valid;
    logic        status_ok;
    logic        busy;
`ifdef GLIP_DEFRAMER_STATS_EN
    logic [15:0] frames_ok;
    logic [15:0] frames_err;
    logic [15:0] resync_drops;
`endif

    int n_cmp = 0;
    int n_err = 0;
    logic tog = 1'b0;

    logic [15:0] exp_d[$];
    logic        exp_l[$];
    logic        exp_s[$];
    logic [15:0] pl_q[$];

    glip_stream_deframer #(
        .SYNC   (4'hA),
        .MAXLEN (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_last     (out_last),
        .status_valid (status_valid),
        .status_ok    (status_ok),
`ifdef GLIP_DEFRAMER_STATS_EN
        .frames_ok    (frames_ok),
        .frames_err   (frames_err),
        .resync_drops (resync_drops),
`endif
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Sink ready: constant 1, or toggling every cycle while tog is set
    initial begin
        forever begin
            @(posedge clk);
            #1;
            out_ready = tog ? !out_ready : 1'b1;
        end
    end

    // Output/status monitor: compares against expectation queues
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid) begin
                if (exp_d.size() == 0) begin
                    check_eq("out_unexpected", {16'h0, out_data}, 32'hDEAD_0000);
                end else begin
                    check_eq("out_data", {16'h0, out_data}, {16'h0, exp_d[0]});
                    check_eq("out_last", {31'h0, out_last}, {31'h0, exp_l[0]});
                    if (out_ready) begin
                        void'(exp_d.pop_front());
                        void'(exp_l.pop_front());
                    end
                end
            end
            if (status_valid) begin
                if (exp_s.size() == 0) begin
                    check_eq("status_unexpected", 32'd1, 32'd0);
                end else begin
                    check_eq("status_ok", {31'h0, status_ok}, {31'h0, exp_s.pop_front()});
                end
            end
        end
    end

    task automatic send_word(input logic [15:0] w);
        int t = 0;
        in_valid = 1'b1;
        in_data  = w;
        forever begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                break;
            end
            t++;
            if (t > 100) begin
                check_eq("in_timeout", 32'd1, 32'd0);
                break;
            end
        end
    endtask

    // Sends header, the words in pl_q, and checksum; queues expectations
    task automatic run_frame(input logic [15:0] hdr, input logic [15:0] csum, input logic ok);
        int n = pl_q.size();
        for (int i = 0; i < n; i++) begin
            exp_d.push_back(pl_q[i]);
            exp_l.push_back(i == n - 1);
        end
        exp_s.push_back(ok);
        send_word(hdr);
        for (int i = 0; i < n; i++) send_word(pl_q[i]);
        send_word(csum);
        pl_q.delete();
    endtask

    task automatic wait_drain();
        int t = 0;
        in_valid = 1'b0;
        while ((exp_d.size() != 0 || exp_s.size() != 0) && t < 200) begin
            @(posedge clk);
            t++;
        end
        @(posedge clk);
        #1;
        check_eq("drain", exp_d.size() + exp_s.size(), 32'd0);
        check_eq("busy_idle", {31'h0, busy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Reset values
        #2;
        check_eq("rst_out_valid", {31'h0, out_valid}, 32'd0);
        check_eq("rst_out_data", {16'h0, out_data}, 32'd0);
        check_eq("rst_out_last", {31'h0, out_last}, 32'd0);
        check_eq("rst_status", {30'h0, status_valid, status_ok}, 32'd0);
        check_eq("rst_busy", {31'h0, busy}, 32'd0);
        check_eq("rst_in_ready", {31'h0, in_ready}, 32'd1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Frame 1 (good) followed back-to-back by frame 2 (bad checksum)
        pl_q = '{16'h0001, 16'h0002, 16'h0003};
        run_frame(16'hA003, 16'h0006, 1'b1);
        pl_q = '{16'h0001, 16'h0002, 16'h0003};
        run_frame(16'hA003, 16'h0007, 1'b0);
        wait_drain();

        // Garbage words are dropped, then a one-word frame
        send_word(16'h1234);
        check_eq("drop1_busy", {31'h0, busy}, 32'd0);
        send_word(16'hB001);
        check_eq("drop2_busy", {31'h0, busy}, 32'd0);
        pl_q = '{16'hFFFF};
        run_frame(16'hA001, 16'hFFFF, 1'b1);
        wait_drain();

        // Wrapping checksum with a toggling sink
        tog = 1'b1;
        pl_q = '{16'h8000, 16'h8000};
        run_frame(16'hA002, 16'h0000, 1'b1);
        wait_drain();
        tog = 1'b0;

        // Empty frame, then an over-length header that must be dropped
        run_frame(16'hA000, 16'h0000, 1'b1);
        wait_drain();
        send_word(16'hA011);
        in_valid = 1'b0;
        check_eq("maxlen_drop_busy", {31'h0, busy}, 32'd0);

        // Exactly MAXLEN payload words: sum 1..16 = 136
        for (int i = 1; i <= 16; i++) pl_q.push_back(16'(i));
        run_frame(16'hA010, 16'h0088, 1'b1);
        wait_drain();

`ifdef GLIP_DEFRAMER_STATS_EN
        check_eq("stat_frames_ok", {16'h0, frames_ok}, 32'd5);
        check_eq("stat_frames_err", {16'h0, frames_err}, 32'd1);
        check_eq("stat_resync_drops", {16'h0, resync_drops}, 32'd3);
`endif

        // Reset after two of three payload words
        exp_d.push_back(16'h0011); exp_l.push_back(1'b0);
        exp_d.push_back(16'h0022); exp_l.push_back(1'b0);
        send_word(16'hA003);
        send_word(16'h0011);
        send_word(16'h0022);
        in_valid = 1'b0;
        check_eq("pre_rst_busy", {31'h0, busy}, 32'd1);
        check_eq("pre_rst_out_valid", {31'h0, out_valid}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        exp_d.delete();
        exp_l.delete();
        check_eq("midrst_out_valid", {31'h0, out_valid}, 32'd0);
        check_eq("midrst_out_data", {16'h0, out_data}, 32'd0);
        check_eq("midrst_status_ok", {31'h0, status_ok}, 32'd0);
        check_eq("midrst_busy", {31'h0, busy}, 32'd0);
`ifdef GLIP_DEFRAMER_STATS_EN
        check_eq("midrst_stats", {16'h0, frames_ok | frames_err | resync_drops}, 32'd0);
`endif
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        pl_q = '{16'h0100, 16'h0200};
        run_frame(16'hA002, 16'h0300, 1'b1);
        wait_drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_glip_stream_deframer
`default_nettype wire
